// File: rtl/layernorm_row_serializer_pkg.sv
// Shared definitions for the layernorm wrapper family: row geometry and FSM encoding.
// Input-side and output-side blocks size their row buses from the same helpers.
package layernorm_row_serializer_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  function automatic int row_w(input int output_width, input int input_num);
    return output_width * input_num;
  endfunction

  // A single-row tensor still needs a 1-bit index port.
  function automatic int idx_w(input int sentence_num);
    return (sentence_num <= 1) ? 1 : $clog2(sentence_num);
  endfunction

endpackage

// File: rtl/layernorm_row_serializer.sv
// Captures a flat layernorm result tensor on a falling edge of result_valid_n and
// streams it out one row per beat over valid(active-low)/ready.
module layernorm_row_serializer
  import layernorm_row_serializer_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 8,
  parameter int SENTENCE_NUM = 128,
  parameter int INPUT_NUM    = 768,
  localparam int ROW_W = row_w(OUTPUT_WIDTH, INPUT_NUM),
  localparam int IDX_W = idx_w(SENTENCE_NUM),
  localparam int TEN_W = ROW_W * SENTENCE_NUM
) (
  input  logic             clk_p,
  input  logic             rst_p,
  input  logic [TEN_W-1:0] result,
  input  logic             result_valid_n,
  output logic [ROW_W-1:0] row_data,
  output logic             row_valid_n,
  input  logic             row_ready,
  output logic [IDX_W-1:0] row_index,
  output logic             row_last_n,
  output logic             busy,
  output logic             frame_done_p,
  output logic             overflow_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SENTENCE_NUM - 1);

  state_e             state_q, state_d;
  logic [TEN_W-1:0]   buf_q, buf_d;
  logic [ROW_W-1:0]   row_q, row_d, next_row;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               vprev_q;
  logic               cap, xfer, at_last;

  assign cap     = ~result_valid_n & vprev_q;
  assign xfer    = vld_q & row_ready;
  assign at_last = (idx_q == LAST_IDX);
  assign idx_nxt = idx_q + 1'b1;

  // Constant-index mux keeps the row select free of wide multiplies.
  always_comb begin
    next_row = '0;
    for (int i = 0; i < SENTENCE_NUM; i++)
      if (idx_nxt == IDX_W'(i)) next_row = buf_q[i*ROW_W +: ROW_W];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    row_d   = row_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          buf_d   = result;
          row_d   = result[ROW_W-1:0];
          idx_d   = '0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer && at_last) begin
          done_d = 1'b1;
          // A capture on the final-beat edge chains straight into the next tensor.
          if (cap) begin
            buf_d = result;
            row_d = result[ROW_W-1:0];
            idx_d = '0;
          end else begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_nxt;
            row_d = next_row;
          end
          if (cap) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state_q <= IDLE;
      buf_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vprev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      vprev_q <= result_valid_n;
    end
  end

  assign row_data     = row_q;
  assign row_valid_n  = ~vld_q;
  assign row_index    = idx_q;
  assign row_last_n   = ~(vld_q & at_last);
  assign busy         = busy_q;
  assign frame_done_p = done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_layernorm_row_serializer.sv
// Directed and randomized checks of the row serializer against a row-queue scoreboard.
module tb_layernorm_row_serializer;
  localparam int OW = 8, SN = 4, IN = 2;
  localparam int RW = OW * IN, TW = RW * SN;

  logic          clk_p = 1'b0, rst_p = 1'b1;
  logic [TW-1:0] result = '0;
  logic          result_valid_n = 1'b1, row_ready = 1'b0;
  logic [RW-1:0] row_data;
  logic          row_valid_n, row_last_n, busy, frame_done_p, overflow_err;
  logic [1:0]    row_index;

  int checks = 0, failures = 0;

  layernorm_row_serializer #(.OUTPUT_WIDTH(OW), .SENTENCE_NUM(SN), .INPUT_NUM(IN)) dut (
    .clk_p(clk_p), .rst_p(rst_p), .result(result), .result_valid_n(result_valid_n),
    .row_data(row_data), .row_valid_n(row_valid_n), .row_ready(row_ready),
    .row_index(row_index), .row_last_n(row_last_n), .busy(busy),
    .frame_done_p(frame_done_p), .overflow_err(overflow_err));

  always #5 clk_p = ~clk_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_p); #1;
  endtask

  // Expected row r of a tensor, taken straight from the flat packing rule.
  function automatic logic [RW-1:0] row_of(input logic [TW-1:0] t, input int r);
    return t[r*RW +: RW];
  endfunction

  task automatic check_beat(input string tag, input logic [TW-1:0] t, input int r);
    check({tag, "_vld"},  row_valid_n, 0);
    check({tag, "_data"}, row_data, row_of(t, r));
    check({tag, "_idx"},  row_index, r);
    check({tag, "_last"}, row_last_n, (r == SN - 1) ? 0 : 1);
  endtask

  logic [TW-1:0] T0, T1, TA, tr;
  logic [RW-1:0] exp_q[$];
  int beats, dones, exp_idx, cyc;

  initial begin
    T0 = 64'h0706_0504_0302_0100;
    T1 = 64'h4444_3333_2222_1111;
    TA = 64'hAAAA_AAAA_AAAA_AAAA;

    // Reset values
    repeat (2) @(posedge clk_p); #1;
    check("rst_vld", row_valid_n, 1);  check("rst_last", row_last_n, 1);
    check("rst_busy", busy, 0);        check("rst_done", frame_done_p, 0);
    check("rst_ovf", overflow_err, 0); check("rst_idx", row_index, 0);
    check("rst_data", row_data, 0);
    rst_p = 1'b0;
    step();

    // Basic stream: one-cycle pulse, ready high
    result = T0; row_ready = 1'b1; result_valid_n = 1'b0;
    step(); result_valid_n = 1'b1;
    check("basic_busy", busy, 1);
    for (int r = 0; r < SN; r++) begin
      check_beat("basic", T0, r);
      check("basic_nodone", frame_done_p, 0);
      step();
    end
    check("basic_done", frame_done_p, 1);
    check("basic_busy_low", busy, 0);
    check("basic_vld_off", row_valid_n, 1);
    step();
    check("basic_done_1cyc", frame_done_p, 0);

    // Backpressure on row 1
    result_valid_n = 1'b0; step(); result_valid_n = 1'b1;
    check_beat("bp0", T0, 0);
    step();
    row_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_beat("bp_hold", T0, 1);
      step();
    end
    check_beat("bp_hold_end", T0, 1);
    row_ready = 1'b1;
    step(); check_beat("bp_resume", T0, 2);
    step(); check_beat("bp3", T0, 3);
    step(); check("bp_done", frame_done_p, 1);

    // Level hold: 20 cycles low yields exactly one tensor
    beats = 0; dones = 0;
    result_valid_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!row_valid_n && row_ready) beats++;
      step();
      if (frame_done_p) dones++;
    end
    result_valid_n = 1'b1;
    check("hold_beats", beats, SN);
    check("hold_dones", dones, 1);
    check("hold_ovf", overflow_err, 0);
    step();

    // Overflow while row 2 pending
    result_valid_n = 1'b0; step(); result_valid_n = 1'b1;
    step(); step();
    check_beat("ovf_row2", T0, 2);
    row_ready = 1'b0; result = TA; result_valid_n = 1'b0;
    step(); result_valid_n = 1'b1;
    check("ovf_set", overflow_err, 1);
    check_beat("ovf_still2", T0, 2);
    row_ready = 1'b1;
    step(); check_beat("ovf_row3", T0, 3);
    step(); check("ovf_done", frame_done_p, 1);
    check("ovf_sticky", overflow_err, 1);
    step(); check("ovf_sticky2", overflow_err, 1);
    rst_p = 1'b1; #2; rst_p = 1'b0;
    check("ovf_cleared", overflow_err, 0);
    step();

    // Back-to-back: capture on the last-beat edge
    result = T0; result_valid_n = 1'b0; step(); result_valid_n = 1'b1;
    step(); step(); step();
    check_beat("b2b_last", T0, 3);
    result = T1; result_valid_n = 1'b0;
    step(); result_valid_n = 1'b1;
    check("b2b_done", frame_done_p, 1);
    check("b2b_busy", busy, 1);
    check("b2b_ovf", overflow_err, 0);
    check_beat("b2b_new0", T1, 0);
    for (int r = 1; r < SN; r++) begin
      step(); check_beat("b2b_new", T1, r);
    end
    step(); check("b2b_done2", frame_done_p, 1);
    step();

    // Reset mid-stream, result_valid_n held low through release
    result = T0; result_valid_n = 1'b0; step(); step();
    check_beat("mrst_row1", T0, 1);
    #2 rst_p = 1'b1; #1;
    check("mrst_vld", row_valid_n, 1); check("mrst_busy", busy, 0);
    check("mrst_data", row_data, 0);   check("mrst_idx", row_index, 0);
    check("mrst_last", row_last_n, 1); check("mrst_done", frame_done_p, 0);
    #1 rst_p = 1'b0;
    step(); result_valid_n = 1'b1;
    check_beat("mrst_recap", T0, 0);
    check("mrst_nodone", frame_done_p, 0);
    repeat (SN) step();
    check("mrst_fin", frame_done_p, 1);
    step();

    // Randomized tensors and ready patterns against a row-queue scoreboard
    for (int it = 0; it < 25; it++) begin
      tr = {$urandom, $urandom};
      result = tr; result_valid_n = 1'b0;
      for (int r = 0; r < SN; r++) exp_q.push_back(row_of(tr, r));
      exp_idx = 0; dones = 0; cyc = 0;
      while ((exp_q.size() != 0 || dones == 0) && cyc < 200) begin
        row_ready = ($urandom_range(0, 3) != 0);
        if (cyc >= int'($urandom_range(1, 3))) result_valid_n = 1'b1;
        if (!row_valid_n && row_ready) begin
          if (exp_q.size() == 0) check("rnd_extra_beat", 1, 0);
          else begin
            check("rnd_data", row_data, exp_q.pop_front());
            check("rnd_idx", row_index, exp_idx);
            check("rnd_last", row_last_n, (exp_idx == SN - 1) ? 0 : 1);
            exp_idx++;
          end
        end
        step(); cyc++;
        if (frame_done_p) dones++;
      end
      check("rnd_timeout", (cyc < 200) ? 1 : 0, 1);
      check("rnd_dones", dones, 1);
      result_valid_n = 1'b1;
      step();
      check("rnd_idle", busy, 0);
      exp_q.delete();
    end
    check("rnd_ovf", overflow_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
